// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the ALU issue path.
// Contents: opcode and funct7 constants, the funct3 operation enum, the issue
// FSM state enum, the decoded-instruction record, and the OP/OP-IMM decoder.
// The decoder takes a 32-bit instruction word. It returns the register
// indices, the ALU controls, the immediate, and a legality flag.
package riscv_pkg;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    F3_ADD     = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic        legal;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7;
    logic        use_imm;
    logic [31:0] imm;
  } decode_t;

  function automatic decode_t decode(input logic [31:0] instr);
    decode_t    d;
    funct3_e    f3;
    logic [6:0] top7;
    d        = '0;
    f3       = funct3_e'(instr[14:12]);
    top7     = instr[31:25];
    d.rd     = instr[11:7];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.funct3 = instr[14:12];
    case (instr[6:0])
      OPC_OP: begin
        d.use_imm = 1'b0;
        d.funct7  = instr[30];
        // The alternate funct7 only selects SUB and SRA.
        d.legal   = (top7 == FUNCT7_ZERO) ||
                    ((top7 == FUNCT7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL_SRA)));
      end
      OPC_OPIMM: begin
        d.use_imm = 1'b1;
        d.funct7  = 1'b0;
        d.imm     = {{20{instr[31]}}, instr[31:20]};
        d.legal   = 1'b1;
        // Shifts take a 5-bit shamt; the upper immediate bits become funct7.
        if (f3 == F3_SLL) begin
          d.imm   = {27'd0, instr[24:20]};
          d.legal = (top7 == FUNCT7_ZERO);
        end else if (f3 == F3_SRL_SRA) begin
          d.imm    = {27'd0, instr[24:20]};
          d.funct7 = instr[30];
          d.legal  = (top7 == FUNCT7_ZERO) || (top7 == FUNCT7_ALT);
        end
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural register file for the ALU issue unit.
// NUM_REGS entries of DATA_WIDTH bits. Entry 0 reads as zero and is never written.
// Ports: clk, rst (sync, clears every entry);
//        raddr1/rdata1 and raddr2/rdata2 are asynchronous operand reads;
//        dbg_addr/dbg_data is an asynchronous debug read;
//        we/waddr/wdata is a synchronous write port.
module alu_issue_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int AW         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [AW-1:0]         raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic [AW-1:0]         dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == '0) ? '0 : mem[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : mem[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue unit: the producer side of the registered-ALU operand interface.
// It accepts RV32I OP/OP-IMM words over valid/ready and decodes them. It
// reads operands from the internal register file, with a bypass from the
// result that is in writeback. It drives the ALU for one cycle, writes the
// result back two edges after the accept, and reports completion.
// Ports: clk, rst (sync, active-high);
//        instr_valid/instr_ready/instr form the instruction handshake;
//        alu_funct3/alu_funct7/alu_opranda/alu_oprandb drive the ALU;
//        alu_res is the registered ALU result (1-cycle latency);
//        done_valid/done_rd/done_data is the completion pulse;
//        illegal pulses when an accepted word is not a legal OP/OP-IMM;
//        dbg_addr/dbg_data is an asynchronous register-file read.
module alu_issue_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  output logic [2:0]            alu_funct3,
  output logic                  alu_funct7,
  output logic [DATA_WIDTH-1:0] alu_opranda,
  output logic [DATA_WIDTH-1:0] alu_oprandb,
  input  logic [DATA_WIDTH-1:0] alu_res,
  output logic                  done_valid,
  output logic [4:0]            done_rd,
  output logic [DATA_WIDTH-1:0] done_data,
  output logic                  illegal,
  input  logic [4:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  import riscv_pkg::*;

  state_e                state_q, state_d;
  decode_t               dec_p0;
  logic                  accept_p0;
  logic                  issue_p0;
  logic                  in_wb;
  logic                  byp1_p0, byp2_p0;
  logic [DATA_WIDTH-1:0] rs1_rdata, rs2_rdata;
  logic [DATA_WIDTH-1:0] opa_p0, opb_p0;
  // Destination of the instruction in flight. It is written at accept and
  // consumed at the writeback edge. Nothing is accepted during EXEC, so it
  // still names the same instruction in WB.
  logic [4:0]            rd_p1;

  assign instr_ready = (state_q != EXEC);
  assign in_wb       = (state_q == WB);
  assign dec_p0      = decode(instr);
  assign accept_p0   = instr_valid && instr_ready;
  assign issue_p0    = accept_p0 && dec_p0.legal;

  alu_issue_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .raddr1   (dec_p0.rs1),
    .rdata1   (rs1_rdata),
    .raddr2   (dec_p0.rs2),
    .rdata2   (rs2_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (in_wb),
    .waddr    (rd_p1),
    .wdata    (alu_res)
  );

  // Stage p0: operand select with RAW bypass from the instruction in WB.
  // Its result reaches the register file on this same edge. alu_res therefore
  // replaces the stale register-file value. x0 is never bypassed.
  always_comb begin
    byp1_p0 = in_wb && (rd_p1 != 5'd0) && (dec_p0.rs1 == rd_p1);
    byp2_p0 = in_wb && (rd_p1 != 5'd0) && (dec_p0.rs2 == rd_p1);
    opa_p0  = byp1_p0 ? alu_res : rs1_rdata;
    opb_p0  = byp2_p0 ? alu_res : rs2_rdata;
    if (dec_p0.use_imm) begin
      opb_p0 = dec_p0.imm[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue_p0) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = issue_p0 ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: ALU issue registers. They are held through EXEC and keep their
  // value until the next legal accept.
  // Stage p2: completion registers, loaded at the writeback edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_opranda <= '0;
      alu_oprandb <= '0;
      rd_p1       <= '0;
      done_valid  <= 1'b0;
      done_rd     <= '0;
      done_data   <= '0;
      illegal     <= 1'b0;
    end else begin
      state_q    <= state_d;
      illegal    <= accept_p0 && !dec_p0.legal;
      done_valid <= in_wb;
      if (in_wb) begin
        done_rd   <= rd_p1;
        done_data <= alu_res;
      end
      if (issue_p0) begin
        alu_funct3  <= dec_p0.funct3;
        alu_funct7  <= dec_p0.funct7;
        alu_opranda <= opa_p0;
        alu_oprandb <= opb_p0;
        rd_p1       <= dec_p0.rd;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_opranda, alu_oprandb, alu_res;
  logic        done_valid;
  logic [4:0]  done_rd;
  logic [31:0] done_data;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_issue_unit #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_funct3  (alu_funct3),
    .alu_funct7  (alu_funct7),
    .alu_opranda (alu_opranda),
    .alu_oprandb (alu_oprandb),
    .alu_res     (alu_res),
    .done_valid  (done_valid),
    .done_rd     (done_rd),
    .done_data   (done_data),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // RV32I integer operation on two operands.
  function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic f7,
                                         input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return f7 ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'd0, $signed(a) < $signed(b)};
      3'd3:    return {31'd0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return f7 ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Registered ALU on the far side of the interface; it resets with rstn = ~rst.
  always_ff @(posedge clk) begin
    if (rst) alu_res <= '0;
    else     alu_res <= alu_op(alu_funct3, alu_funct7, alu_opranda, alu_oprandb);
  end

  // Reference model: architectural state plus the instructions in flight.
  logic [31:0] m_rf [32];
  bit          ex_pend, wb_pend;
  logic [4:0]  ex_rd, wb_rd;
  logic [31:0] ex_data, wb_data;
  logic        exp_ready, exp_done_v, exp_ill, exp_f7;
  logic [4:0]  exp_done_rd;
  logic [31:0] exp_done_data, exp_a, exp_b;
  logic [2:0]  exp_f3;

  function automatic logic [31:0] reg_val(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : m_rf[idx];
  endfunction

  // Advance the model by one clock edge with the inputs that edge sampled.
  task automatic model_edge(input logic r, input logic v, input logic [31:0] w);
    logic [6:0]  opc, top7;
    logic [2:0]  f3;
    logic        ok, f7b;
    logic [31:0] a, b;
    if (r) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      ex_pend = 0; wb_pend = 0;
      exp_done_v = 0; exp_done_rd = 0; exp_done_data = 0; exp_ill = 0;
      exp_f3 = 0; exp_f7 = 0; exp_a = 0; exp_b = 0;
    end else begin
      exp_done_v = 0;
      exp_ill    = 0;
      if (wb_pend) begin
        if (wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
        exp_done_v = 1; exp_done_rd = wb_rd; exp_done_data = wb_data;
        wb_pend = 0;
      end
      if (ex_pend) begin
        wb_pend = 1; wb_rd = ex_rd; wb_data = ex_data; ex_pend = 0;
      end else if (v) begin
        opc = w[6:0]; f3 = w[14:12]; top7 = w[31:25];
        ok = 0; f7b = 0; b = 32'd0;
        a = reg_val(w[19:15]);
        if (opc == 7'h33) begin
          ok  = (top7 == 7'h00) || (top7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
          f7b = w[30];
          b   = reg_val(w[24:20]);
        end else if (opc == 7'h13) begin
          if (f3 == 3'd1) begin
            ok = (top7 == 7'h00); b = {27'd0, w[24:20]};
          end else if (f3 == 3'd5) begin
            ok = (top7 == 7'h00) || (top7 == 7'h20); b = {27'd0, w[24:20]}; f7b = w[30];
          end else begin
            ok = 1; b = {{20{w[31]}}, w[31:20]};
          end
        end
        if (!ok) exp_ill = 1;
        else begin
          exp_f3 = f3; exp_f7 = f7b; exp_a = a; exp_b = b;
          ex_pend = 1; ex_rd = w[11:7]; ex_data = alu_op(f3, f7b, a, b);
        end
      end
    end
    exp_ready = !ex_pend;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",     {31'd0, instr_ready}, {31'd0, exp_ready});
      chk("done_v",    {31'd0, done_valid},  {31'd0, exp_done_v});
      chk("done_rd",   {27'd0, done_rd},     {27'd0, exp_done_rd});
      chk("done_data", done_data,            exp_done_data);
      chk("illegal",   {31'd0, illegal},     {31'd0, exp_ill});
      chk("funct3",    {29'd0, alu_funct3},  {29'd0, exp_f3});
      chk("funct7",    {31'd0, alu_funct7},  {31'd0, exp_f7});
      chk("opranda",   alu_opranda,          exp_a);
      chk("oprandb",   alu_oprandb,          exp_b);
      chk("dbg",       dbg_data,             reg_val(dbg_addr));
    end
  end

  task automatic step(input logic r, input logic v, input logic [31:0] w);
    rst = r; instr_valid = v; instr = w;
    dbg_addr = 5'($urandom_range(0, 31));
    @(posedge clk);
    model_edge(r, v, w);
    #3;
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk("lit_dbg", dbg_data, exp);
  endtask

  task automatic lit_done(input logic [4:0] rd, input logic [31:0] data);
    chk("lit_done_v",    {31'd0, done_valid}, 32'd1);
    chk("lit_done_rd",   {27'd0, done_rd},    {27'd0, rd});
    chk("lit_done_data", done_data,           data);
  endtask

  task automatic issue(input logic [31:0] w);
    step(0, 1, w); step(0, 0, 0); step(0, 0, 0);
  endtask

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        return itype(imm, rnd_reg(), f3, rnd_reg());
      end
      4, 5, 6: begin
        f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
        return rtype(f7, rnd_reg(), rnd_reg(), f3, rnd_reg());
      end
      7:       return $urandom;
      8:       return itype(imm, rnd_reg(), f3, rnd_reg());
      default: return rtype(7'($urandom), rnd_reg(), rnd_reg(), f3, rnd_reg());
    endcase
  endfunction

  initial begin
    rst = 1; instr_valid = 0; instr = 0; dbg_addr = 0;

    // Reset, then every register reads zero and the unit is ready.
    step(1, 0, 0);
    chk_en = 1;
    step(1, 0, 0);
    step(0, 0, 0);
    chk("lit_ready", {31'd0, instr_ready}, 32'd1);
    chk("lit_no_done", {31'd0, done_valid}, 32'd0);
    for (int i = 1; i < 32; i++) begin
      step(0, 0, 0);
      peek(5'(i), 32'd0);
    end

    // Back-to-back ADDIs, then ADD and SUB.
    step(0, 1, itype(12'd10, 5'd0, 3'd0, 5'd1));
    step(0, 0, 0);
    step(0, 1, itype(12'd5, 5'd0, 3'd0, 5'd2));
    lit_done(5'd1, 32'd10);
    step(0, 0, 0);
    step(0, 0, 0);
    lit_done(5'd2, 32'd5);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    lit_done(5'd3, 32'd15);
    issue(rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd4));
    lit_done(5'd4, 32'd5);

    // Bypass into SRAI, then SRLI.
    step(0, 1, itype(12'hFF0, 5'd0, 3'd0, 5'd5));
    step(0, 0, 0);
    step(0, 1, itype({7'h20, 5'd2}, 5'd5, 3'd5, 5'd6));
    lit_done(5'd5, 32'hFFFF_FFF0);
    step(0, 0, 0);
    step(0, 0, 0);
    lit_done(5'd6, 32'hFFFF_FFFC);
    issue(itype(12'd2, 5'd5, 3'd5, 5'd7));
    lit_done(5'd7, 32'h3FFF_FFFC);

    // SLTI, SLTIU, and a write to x0.
    issue(itype(12'd20, 5'd1, 3'd2, 5'd8));
    lit_done(5'd8, 32'd1);
    issue(itype(12'd1, 5'd5, 3'd3, 5'd9));
    lit_done(5'd9, 32'd0);
    issue(itype(12'd7, 5'd0, 3'd0, 5'd0));
    lit_done(5'd0, 32'd7);
    step(0, 0, 0);
    peek(5'd0, 32'd0);

    // Illegal words: JAL, SLLI with the alternate funct7, and XOR with the alternate funct7.
    step(0, 1, 32'h0000_006F);
    chk("lit_ill_jal", {31'd0, illegal}, 32'd1);
    chk("lit_ill_ready", {31'd0, instr_ready}, 32'd1);
    step(0, 1, itype({7'h20, 5'd3}, 5'd1, 3'd1, 5'd11));
    chk("lit_ill_slli", {31'd0, illegal}, 32'd1);
    step(0, 1, rtype(7'h20, 5'd2, 5'd1, 3'd4, 5'd12));
    chk("lit_ill_xor", {31'd0, illegal}, 32'd1);
    step(0, 0, 0);
    chk("lit_ill_clear", {31'd0, illegal}, 32'd0);
    chk("lit_ill_nodone", {31'd0, done_valid}, 32'd0);
    peek(5'd11, 32'd0);
    step(0, 0, 0);
    peek(5'd12, 32'd0);
    step(0, 0, 0);
    peek(5'd1, 32'd10);

    // Reset during EXEC drops the instruction.
    step(0, 1, itype(12'd1, 5'd0, 3'd0, 5'd10));
    step(1, 0, 0);
    step(0, 0, 0);
    chk("lit_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("lit_rst_nodone", {31'd0, done_valid}, 32'd0);
    peek(5'd10, 32'd0);
    step(0, 0, 0);
    chk("lit_rst_nodone2", {31'd0, done_valid}, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), rnd_instr());
    end
    for (int n = 0; n < 4; n++) step(0, 0, 0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
